instr_fetch_unit: RTL and testbench

Instruction fetch stage for the Complex CPU. It drives the address bus of the asynchronous instruction ROM and latches the returned 38-bit word into an instruction register. It splits that word into opcode, select and two 16-bit operand fields, and presents them to the execute stage over a valid/ready handshake. It also handles jump redirects from execute, PC wrap-around and an optional HALT stop.

---
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Instruction fetch stage: drives the asynchronous ROM address from the PC,
// latches the returned word into the instruction register and presents the
// decoded fields to execute over a valid/ready handshake. Handles jump
// redirects and PC wrap-around.
// Optional feature macro: FETCH_HALT_EN (stop fetching after an opcode 4'hF
// word until a jump or reset). Without the macro, 4'hF is an ordinary opcode.
//
// Handshake: instr_valid stays high and the decoded fields stay stable until
// an edge where instr_valid and instr_ready are both 1; that edge completes
// the transfer. A jump drops instr_valid without reloading ir, but a transfer
// completing on the same edge is still a completed transfer.
module instr_fetch_unit #(
  parameter int DATA_WIDTH = 38,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [3:0]            opcode,
  output logic [1:0]            sel,
  output logic [15:0]           op_a,
  output logic [15:0]           op_b,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  jmp_en,
  input  logic [ADDR_WIDTH-1:0] jmp_addr,
  output logic                  halted
);

  // Field positions within the instruction word: OPCODE s a b.
  localparam int OPC_MSB = DATA_WIDTH - 1;
  localparam int SEL_MSB = DATA_WIDTH - 5;
  localparam logic [3:0] HALT_OPCODE = 4'hF;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  valid_q, valid_d;

  logic load;
  logic halt_load;

  // A new word is fetched when running, not redirecting, and the IR slot is
  // empty or being emptied this edge.
  assign load = (state_q == RUN) && !jmp_en && (!valid_q || instr_ready);

`ifdef FETCH_HALT_EN
  // The word being loaded right now is a HALT.
  assign halt_load = load && (instruction[OPC_MSB -: 4] == HALT_OPCODE);
`else
  assign halt_load = 1'b0;
`endif

  // State register for the RUN/HALTED FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a jump always resumes RUN and takes priority over HALT.
  always_comb begin
    state_d = state_q;
    if (jmp_en) begin
      state_d = RUN;
    end else if (halt_load) begin
      state_d = HALTED;
    end
  end

  // FSM output: halted flag mirrors the state.
  always_comb begin
`ifdef FETCH_HALT_EN
    halted = (state_q == HALTED);
`else
    halted = 1'b0;
`endif
  end

  // Datapath next-state: jump beats load; otherwise load, or drop valid on
  // a completed transfer with nothing new to load.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (jmp_en) begin
      pc_d    = jmp_addr;
      valid_d = 1'b0;
    end else if (load) begin
      ir_d       = instruction;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      // A HALT word freezes the PC on itself; otherwise advance with wrap.
      pc_d       = halt_load ? pc_q : (pc_q + PC_ONE);
    end else if (valid_q && instr_ready) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      ir_q       <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  // Outputs are pure register slices; nothing passes straight from the ROM.
  assign address     = pc_q;
  assign instr_valid = valid_q;
  assign instr_pc    = instr_pc_q;
  assign opcode      = ir_q[OPC_MSB -: 4];
  assign sel         = ir_q[SEL_MSB -: 2];
  assign op_a        = ir_q[31:16];
  assign op_b        = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM model, per-scenario tasks with inline
// checks, and an expected queue of {pc, word} popped on every handshake.
module tb_instr_fetch_unit;

  localparam int DW = 38;
  localparam int AW = 12;
  localparam int EW = AW + DW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] address;
  logic [DW-1:0] instruction;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    opcode;
  logic [1:0]    sel;
  logic [15:0]   op_a;
  logic [15:0]   op_b;
  logic [AW-1:0] instr_pc;
  logic          jmp_en;
  logic [AW-1:0] jmp_addr;
  logic          halted;

  logic [DW-1:0] rom [0:(1<<AW)-1];
  logic [EW-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .sel         (sel),
    .op_a        (op_a),
    .op_b        (op_b),
    .instr_pc    (instr_pc),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .halted      (halted)
  );

  // Asynchronous ROM.
  assign instruction = rom[address];

  // Clock / reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Push the word expected to be accepted from a given pc.
  task automatic push_exp(input logic [AW-1:0] pc);
    exp_q.push_back({pc, rom[pc]});
  endtask

  // Advance one clock; at the falling edge retire any handshake that the
  // next rising edge will complete against the expected queue.
  task automatic cycle();
    logic [EW-1:0] e;
    @(negedge clk);
    if (rst_n && instr_valid && instr_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: accepted instr_pc=%0h, required no accept", instr_pc);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, opcode, sel, op_a, op_b} !== e) begin
          bad++;
          $display("FAIL sb_accept: got pc=%0h word=%0h, required pc=%0h word=%0h",
                   instr_pc, {opcode, sel, op_a, op_b}, e[EW-1 -: AW], e[DW-1:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; instr_ready = 1'b1; jmp_en = 1'b0; jmp_addr = '0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({instr_valid, address, instr_pc, opcode, sel, op_a, op_b, halted} !== '0) begin
      bad++;
      $display("FAIL reset_async: got valid=%b addr=%0h pc=%0h ir=%0h halted=%b, required all 0",
               instr_valid, address, instr_pc, {opcode, sel, op_a, op_b}, halted);
    end
    cycle();
    cycle();
    total++;
    if ({instr_valid, address, instr_pc, opcode, sel, op_a, op_b, halted} !== '0) begin
      bad++;
      $display("FAIL reset_held: got valid=%b addr=%0h pc=%0h, required all 0",
               instr_valid, address, instr_pc);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) push_exp(AW'(i));
    rst_n = 1'b1;
    cycle();
    total++;
    if ({instr_valid, opcode, op_a, op_b, instr_pc, address} !==
        {1'b1, 4'h1, 16'h0000, 16'h000F, 12'h000, 12'h001}) begin
      bad++;
      $display("FAIL stream_c1: got v=%b opc=%0h a=%0h b=%0h pc=%0h addr=%0h, required v=1 opc=1 a=0 b=f pc=0 addr=1",
               instr_valid, opcode, op_a, op_b, instr_pc, address);
    end
    cycle();
    total++;
    if ({instr_valid, op_a, op_b, instr_pc} !== {1'b1, 16'h1000, 16'h00FF, 12'h001}) begin
      bad++;
      $display("FAIL stream_c2: got v=%b a=%0h b=%0h pc=%0h, required v=1 a=1000 b=ff pc=1",
               instr_valid, op_a, op_b, instr_pc);
    end
    cycle();
    cycle();
    total++;
    if (instr_pc !== 12'h003) begin
      bad++;
      $display("FAIL stream_c4: got pc=%0h, required pc=3", instr_pc);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if ({instr_valid, instr_pc, address, op_b} !== {1'b1, 12'h003, 12'h004, rom[3][15:0]}) begin
        bad++;
        $display("FAIL backpressure_hold: got v=%b pc=%0h addr=%0h b=%0h, required v=1 pc=3 addr=4 b=%0h",
                 instr_valid, instr_pc, address, op_b, rom[3][15:0]);
      end
    end
    push_exp(AW'(4));
    instr_ready = 1'b1;
    cycle();
    total++;
    if ({instr_valid, instr_pc, address} !== {1'b1, 12'h004, 12'h005}) begin
      bad++;
      $display("FAIL backpressure_release: got v=%b pc=%0h addr=%0h, required v=1 pc=4 addr=5",
               instr_valid, instr_pc, address);
    end
  endtask

  task automatic test_jump();
    // Instruction 4 is accepted on the jump edge.
    jmp_en = 1'b1; jmp_addr = 12'h020;
    cycle();
    jmp_en = 1'b0;
    total++;
    if ({instr_valid, address, instr_pc} !== {1'b0, 12'h020, 12'h004}) begin
      bad++;
      $display("FAIL jump_redirect: got v=%b addr=%0h pc=%0h, required v=0 addr=20 pc=4",
               instr_valid, address, instr_pc);
    end
    push_exp(AW'(32));
    cycle();
    total++;
    if ({instr_valid, instr_pc, address} !== {1'b1, 12'h020, 12'h021}) begin
      bad++;
      $display("FAIL jump_target: got v=%b pc=%0h addr=%0h, required v=1 pc=20 addr=21",
               instr_valid, instr_pc, address);
    end
  endtask

  task automatic test_wrap();
    jmp_en = 1'b1; jmp_addr = 12'hFFF;
    cycle();
    jmp_en = 1'b0;
    total++;
    if ({instr_valid, address} !== {1'b0, 12'hFFF}) begin
      bad++;
      $display("FAIL wrap_redirect: got v=%b addr=%0h, required v=0 addr=fff", instr_valid, address);
    end
    push_exp(AW'(4095));
    push_exp(AW'(0));
    cycle();
    total++;
    if ({instr_valid, instr_pc, address} !== {1'b1, 12'hFFF, 12'h000}) begin
      bad++;
      $display("FAIL wrap_top: got v=%b pc=%0h addr=%0h, required v=1 pc=fff addr=0",
               instr_valid, instr_pc, address);
    end
    cycle();
    total++;
    if ({instr_valid, instr_pc, address} !== {1'b1, 12'h000, 12'h001}) begin
      bad++;
      $display("FAIL wrap_zero: got v=%b pc=%0h addr=%0h, required v=1 pc=0 addr=1",
               instr_valid, instr_pc, address);
    end
    cycle();
    instr_ready = 1'b0;
    total++;
    if (instr_pc !== 12'h001) begin
      bad++;
      $display("FAIL wrap_next: got pc=%0h, required pc=1", instr_pc);
    end
  endtask

  task automatic test_halt();
    logic [DW-1:0] saved;
    saved = rom[2];
    rom[2] = {4'hF, 2'b01, 16'h2222, 16'h3333};
    push_exp(AW'(1));
    push_exp(AW'(2));
`ifndef FETCH_HALT_EN
    push_exp(AW'(3));
    push_exp(AW'(4));
`endif
    instr_ready = 1'b1;
    cycle();
`ifdef FETCH_HALT_EN
    total++;
    if ({instr_valid, instr_pc, opcode, halted, address} !== {1'b1, 12'h002, 4'hF, 1'b1, 12'h002}) begin
      bad++;
      $display("FAIL halt_load: got v=%b pc=%0h opc=%0h halted=%b addr=%0h, required v=1 pc=2 opc=f halted=1 addr=2",
               instr_valid, instr_pc, opcode, halted, address);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++;
      if ({instr_valid, halted, address, instr_pc} !== {1'b0, 1'b1, 12'h002, 12'h002}) begin
        bad++;
        $display("FAIL halt_frozen: got v=%b halted=%b addr=%0h pc=%0h, required v=0 halted=1 addr=2 pc=2",
                 instr_valid, halted, address, instr_pc);
      end
    end
`else
    total++;
    if ({instr_valid, instr_pc, opcode, halted, address} !== {1'b1, 12'h002, 4'hF, 1'b0, 12'h003}) begin
      bad++;
      $display("FAIL halt_off_load: got v=%b pc=%0h opc=%0h halted=%b addr=%0h, required v=1 pc=2 opc=f halted=0 addr=3",
               instr_valid, instr_pc, opcode, halted, address);
    end
    cycle();
    total++;
    if ({instr_valid, instr_pc, halted} !== {1'b1, 12'h003, 1'b0}) begin
      bad++;
      $display("FAIL halt_off_next: got v=%b pc=%0h halted=%b, required v=1 pc=3 halted=0",
               instr_valid, instr_pc, halted);
    end
    cycle();
    total++;
    if (instr_pc !== 12'h004) begin
      bad++;
      $display("FAIL halt_off_stream: got pc=%0h, required pc=4", instr_pc);
    end
`endif
    jmp_en = 1'b1; jmp_addr = 12'h000;
    cycle();
    jmp_en = 1'b0;
    total++;
    if ({instr_valid, halted, address} !== {1'b0, 1'b0, 12'h000}) begin
      bad++;
      $display("FAIL halt_resume_jump: got v=%b halted=%b addr=%0h, required v=0 halted=0 addr=0",
               instr_valid, halted, address);
    end
    cycle();
    instr_ready = 1'b0;
    total++;
    if ({instr_valid, instr_pc, halted, address} !== {1'b1, 12'h000, 1'b0, 12'h001}) begin
      bad++;
      $display("FAIL halt_resume_load: got v=%b pc=%0h halted=%b addr=%0h, required v=1 pc=0 halted=0 addr=1",
               instr_valid, instr_pc, halted, address);
    end
    rom[2] = saved;
  endtask

  task automatic test_back_to_back();
    int idx;
    logic r;
    idx = 0;
    for (int i = 0; i < 150; i++) begin
      r = 1'($urandom_range(0, 1));
      instr_ready = r;
      if (r) begin
        push_exp(AW'(idx));
        idx++;
      end
      cycle();
      total++;
      if ({instr_valid, instr_pc} !== {1'b1, AW'(idx)}) begin
        bad++;
        $display("FAIL b2b_pc: got v=%b pc=%0h, required v=1 pc=%0h", instr_valid, instr_pc, idx);
      end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({instr_valid, address, instr_pc, opcode, sel, op_a, op_b, halted} !== '0) begin
      bad++;
      $display("FAIL reset_mid_async: got v=%b addr=%0h pc=%0h ir=%0h, required all 0",
               instr_valid, address, instr_pc, {opcode, sel, op_a, op_b});
    end
    cycle();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    push_exp(AW'(0));
    cycle();
    total++;
    if ({instr_valid, instr_pc, op_b} !== {1'b1, 12'h000, 16'h000F}) begin
      bad++;
      $display("FAIL reset_mid_first: got v=%b pc=%0h b=%0h, required v=1 pc=0 b=f",
               instr_valid, instr_pc, op_b);
    end
    cycle();
    instr_ready = 1'b0;
    total++;
    if (instr_pc !== 12'h001) begin
      bad++;
      $display("FAIL reset_mid_second: got pc=%0h, required pc=1", instr_pc);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      rom[i] = {4'($urandom_range(0, 14)), 2'($urandom_range(0, 3)),
                16'($urandom), 16'($urandom)};
    end
    rom[0] = {4'h1, 2'b00, 16'h0000, 16'h000F};
    rom[1] = {4'h1, 2'b00, 16'h1000, 16'h00FF};

    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_wrap();
    test_halt();
    test_back_to_back();
    test_reset_mid();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
